axi_mux_slice: RTL and testbench
================================

# axi_mux_slice

Registered, handshaked N-to-1 channel multiplexer for the AXI node datapath. It selects one of `N_IN` valid/ready input channels with `sel_i` and forwards accepted beats through a registered output stage, tagging each beat with its source index. It replaces the purely combinational select path wherever a timing cut and per-beat backpressure are needed, for example between the request arbiter and a slave port.

## Interface
- `DATA_WIDTH`, 64, payload width per channel.
- `N_IN`, 16, number of input channels; must be ≥ 2.
- `SEL_WIDTH`, `$clog2(N_IN)`, select and tag width.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid_i` input N_IN: per-channel valid.
- `in_data_i` input N_IN*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `in_ready_o` output N_IN: per-channel ready; at most one bit set.
- `sel_i` input SEL_WIDTH: channel select, sampled every cycle.
- `out_valid_o` output 1: output beat valid.
- `out_data_o` output DATA_WIDTH: output payload.
- `out_sel_o` output SEL_WIDTH: source channel index of the current output beat.
- `out_ready_i` input 1: downstream ready.
- `sel_err_o` output 1: one-cycle pulse, registered, set when the selected input is valid but `sel_i >= N_IN`.

## Operation
- Transfer on channel k: `in_valid_i[k] && in_ready_o[k]` at a rising edge.
- `in_ready_o[k] = (sel_i == k) && can_accept`. All other bits are 0.
- If `sel_i >= N_IN`, all `in_ready_o` bits are 0 and nothing is accepted.
- An accepted beat stores `{data, sel_i}` in the output stage. `out_sel_o` always matches the index the beat was accepted from.
- The output beat is held stable, with `out_valid_o` high, until `out_ready_i` is high at an edge.
- `sel_i` may change on any cycle. This never alters a beat already held in the stage.
- `sel_err_o` follows `(sel_i >= N_IN) && |in_valid_i`, registered one cycle. When `N_IN` is a power of two it is tied to 0.
- Without the skid buffer, the stage is a single entry:
  - `can_accept = !out_valid_o || out_ready_i`. This is a combinational path from `out_ready_i`.
  - A simultaneous pop and push in the same cycle is allowed and loses no bandwidth.
- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_sel_o`=0, `sel_err_o`=0, and all internal storage cleared.
- Reset asserted mid-transfer discards any held beats immediately, asynchronously. There is no replay.

## Timing
- Latency is one cycle: a beat accepted at edge n is presented on `out_*` after edge n.
- Throughput is one beat per cycle while `out_ready_i` stays high.
- Without the skid buffer, `in_ready_o` depends combinationally on `sel_i`, `out_valid_o` and `out_ready_i`.
- With the skid buffer, `can_accept` comes from registers only. `in_ready_o` then depends combinationally on `sel_i` alone.
- `out_*` are driven directly from flops in both configurations.

## Configuration
- `AXI_MUX_SKID_EN` defined: the stage is a two-entry skid buffer with states EMPTY, ONE and TWO.
  - `can_accept = (state != TWO)`.
  - Transitions:
    - EMPTY→ONE on push.
    - ONE→TWO on push without pop.
    - ONE→EMPTY on pop without push.
    - ONE stays ONE on push with pop.
    - TWO→ONE on pop; push is impossible in TWO.
  - Output order is strictly FIFO.
  - After `out_ready_i` falls, at most one extra beat is absorbed.
- `AXI_MUX_SKID_EN` undefined: the stage is the single-entry form described in Operation, with the combinational ready path.

## Test plan
- Reset release, `sel_i`=3, `in_valid_i[3]`=1 with data 0xA5 → `in_ready_o`=0x0008. On the next cycle `out_valid_o`=1, `out_data_o`=0xA5, `out_sel_o`=3.
- `out_ready_i` held 1, `sel_i` stepping 0,1,2,… each cycle, every input valid with data = index → one beat per cycle, `out_sel_o` equals `out_data_o`, no gaps.
- `out_ready_i`=0 for 4 cycles with input 5 valid:
  - Without skid: exactly 1 beat held and `in_ready_o[5]`=0 after 1 accept.
  - With skid: exactly 2 beats held and `in_ready_o[5]`=0 after 2 accepts.
  - Both: order preserved on release.
- `sel_i` changed from 2 to 7 while the beat from 2 is held → `out_sel_o` stays 2 and the data is unchanged until it is popped.
- `N_IN`=5, `sel_i`=6, `in_valid_i`=0x1F → `in_ready_o`=0, no output beat, `sel_err_o`=1 for one cycle after the edge.
- `rst_n` driven low asynchronously while 2 beats are held → `out_valid_o` drops to 0 before the next clock edge. After release the state is EMPTY.

Source files
------------

// File: rtl/axi_mux_slice_if.sv
// rtl/axi_mux_slice_if.sv - channel bundle between upstream sources, the mux slice and the downstream sink
interface axi_mux_slice_if #(
    parameter int DATA_WIDTH = 64,
    parameter int N_IN       = 16,
    parameter int SEL_WIDTH  = $clog2(N_IN)
);
    logic [N_IN-1:0]            in_valid_i;
    logic [N_IN*DATA_WIDTH-1:0] in_data_i;
    logic [N_IN-1:0]            in_ready_o;
    logic [SEL_WIDTH-1:0]       sel_i;
    logic                       out_valid_o;
    logic [DATA_WIDTH-1:0]      out_data_o;
    logic [SEL_WIDTH-1:0]       out_sel_o;
    logic                       out_ready_i;
    logic                       sel_err_o;

    // Environment side: drives the sources, the select and the downstream ready.
    modport master (
        output in_valid_i, in_data_i, sel_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_sel_o, sel_err_o
    );

    // Slice side.
    modport slave (
        input  in_valid_i, in_data_i, sel_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_sel_o, sel_err_o
    );
endinterface

// File: rtl/axi_mux_slice.sv
// rtl/axi_mux_slice.sv - registered N-to-1 handshaked mux with source tag; AXI_MUX_SKID_EN selects the two-entry skid stage
module axi_mux_slice #(
    parameter int DATA_WIDTH = 64,
    parameter int N_IN       = 16,
    parameter int SEL_WIDTH  = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_mux_slice_if.slave    bus
);

    // With a power-of-two channel count every select code is a real channel.
    localparam bit SEL_POW2 = ((N_IN & (N_IN - 1)) == 0);

    logic                  sel_ok;
    logic                  can_accept;
    logic                  push;
    logic                  pop;
    logic [N_IN-1:0]       ready;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [SEL_WIDTH-1:0]  out_sel_q;
    logic                  sel_err_q;

    assign sel_ok = (32'(bus.sel_i) < N_IN);

    // One-hot ready and payload select; an out-of-range select matches no channel.
    always_comb begin
        ready    = '0;
        sel_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (bus.sel_i == SEL_WIDTH'(k)) begin
                ready[k] = can_accept;
                sel_data = bus.in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.in_ready_o  = ready;
    assign push            = |(bus.in_valid_i & ready);
    assign pop             = out_valid_q & bus.out_ready_i;

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_sel_o   = out_sel_q;
    assign bus.sel_err_o   = sel_err_q;

    // Flag a valid request aimed at a non-existent channel, one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= !SEL_POW2 && !sel_ok && (|bus.in_valid_i);
        end
    end

`ifdef AXI_MUX_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [SEL_WIDTH-1:0]  skid_sel;

    // Ready is a function of registered occupancy only, cutting the out_ready path.
    assign can_accept = (state != TWO);

    // Head register feeds the outputs; the skid register catches the beat in flight when the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            skid_data   <= '0;
            skid_sel    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_data_q  <= sel_data;
                        out_sel_q   <= bus.sel_i;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_data_q <= sel_data;
                        out_sel_q  <= bus.sel_i;
                    end else if (push) begin
                        skid_data <= sel_data;
                        skid_sel  <= bus.sel_i;
                        state     <= TWO;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        out_data_q <= skid_data;
                        out_sel_q  <= skid_sel;
                        state      <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

`else

    // A beat may enter whenever the stage is empty or is being drained this cycle.
    assign can_accept = !out_valid_q || bus.out_ready_i;

    // Single-entry stage: load on push (also covers simultaneous pop), clear valid on a bare pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (push) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_sel_q   <= bus.sel_i;
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_axi_mux_slice.sv
// tb/tb_axi_mux_slice.sv - directed scoreboard bench for axi_mux_slice
module tb_axi_mux_slice;

`ifdef AXI_MUX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_mux_slice_if #(.DATA_WIDTH(64), .N_IN(16)) bus16 ();
    axi_mux_slice_if #(.DATA_WIDTH(64), .N_IN(5))  bus5 ();

    axi_mux_slice #(.DATA_WIDTH(64), .N_IN(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    axi_mux_slice #(.DATA_WIDTH(64), .N_IN(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [67:0] q[$];
    logic [63:0] d16[16];
    logic [15:0] v16;
    logic [3:0]  s16;
    logic        ordy16;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus16.in_valid_i  = v16;
        bus16.sel_i       = s16;
        bus16.out_ready_i = ordy16;
        for (int k = 0; k < 16; k++) bus16.in_data_i[k*64 +: 64] = d16[k];
    endtask

    // One clock of the 16-channel DUT: check outputs and ready against the model, then advance it.
    task automatic cycle(input string tag);
        bit          rdy;
        bit          push;
        bit          pop;
        logic [67:0] front;
        apply();
        @(negedge clk);
        rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy16);
        chk({tag, ":out_valid"}, 68'(bus16.out_valid_o), 68'(q.size() > 0));
        if (q.size() > 0) begin
            front = q[0];
            chk({tag, ":out_data"}, 68'(bus16.out_data_o), 68'(front[63:0]));
            chk({tag, ":out_sel"},  68'(bus16.out_sel_o),  68'(front[67:64]));
        end
        chk({tag, ":in_ready"}, 68'(bus16.in_ready_o), rdy ? 68'(16'h1 << s16) : 68'h0);
        push = v16[s16] && rdy;
        pop  = (q.size() > 0) && ordy16;
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({s16, d16[s16]});
    endtask

    initial begin
        rst_n  = 1'b0;
        v16    = '0;
        s16    = '0;
        ordy16 = 1'b0;
        for (int k = 0; k < 16; k++) d16[k] = '0;
        bus5.in_valid_i  = '0;
        bus5.in_data_i   = '0;
        bus5.sel_i       = '0;
        bus5.out_ready_i = 1'b1;
        apply();
        #12;

        // Reset state
        chk("rst:out_valid16", 68'(bus16.out_valid_o), 68'h0);
        chk("rst:out_data16",  68'(bus16.out_data_o),  68'h0);
        chk("rst:out_sel16",   68'(bus16.out_sel_o),   68'h0);
        chk("rst:sel_err16",   68'(bus16.sel_err_o),   68'h0);
        chk("rst:out_valid5",  68'(bus5.out_valid_o),  68'h0);
        chk("rst:sel_err5",    68'(bus5.sel_err_o),    68'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First beat from channel 3
        s16 = 4'd3; v16 = 16'h0008; d16[3] = 64'hA5; ordy16 = 1'b1;
        cycle("t1_accept");
        v16 = '0;
        cycle("t1_out");
        cycle("t1_idle");

        // Full-rate streaming across all channels
        for (int k = 0; k < 16; k++) d16[k] = 64'(k);
        v16 = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            s16 = 4'(k);
            cycle("t2_stream");
        end
        v16 = '0;
        cycle("t2_drain");
        cycle("t2_idle");

        // Backpressure on channel 5
        ordy16 = 1'b0; s16 = 4'd5; v16 = 16'h0020;
        for (int i = 0; i < 4; i++) begin
            d16[5] = 64'h500 + 64'(i);
            cycle("t3_hold");
        end
        chk("t3:full_ready", 68'(bus16.in_ready_o), 68'h0);
        ordy16 = 1'b1; v16 = '0;
        for (int i = 0; i < 3; i++) cycle("t3_release");

        // Select moves away while a beat from channel 2 is held
        ordy16 = 1'b0; s16 = 4'd2; v16 = 16'h0004; d16[2] = 64'h222;
        cycle("t4_push");
        v16 = '0; s16 = 4'd7;
        for (int i = 0; i < 3; i++) cycle("t4_held");
        ordy16 = 1'b1;
        cycle("t4_pop");
        cycle("t4_idle");

        // Out-of-range select on the five-channel instance
        bus5.sel_i      = 3'd6;
        bus5.in_valid_i = 5'h1F;
        bus5.in_data_i  = {5{64'h0F0F}};
        #1;
        chk("t5:in_ready5", 68'(bus5.in_ready_o), 68'h0);
        @(posedge clk);
        #1;
        bus5.in_valid_i = '0;
        chk("t5:sel_err_set", 68'(bus5.sel_err_o),   68'h1);
        chk("t5:no_beat",     68'(bus5.out_valid_o), 68'h0);
        @(posedge clk);
        #1;
        chk("t5:sel_err_clr", 68'(bus5.sel_err_o),   68'h0);
        chk("t5:no_beat2",    68'(bus5.out_valid_o), 68'h0);

        // Asynchronous reset while beats are held
        ordy16 = 1'b0; s16 = 4'd9; v16 = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            d16[9] = 64'h900 + 64'(i);
            cycle("t6_fill");
        end
        v16 = '0;
        apply();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6:async_drop", 68'(bus16.out_valid_o), 68'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
